// File: rtl/display_scanout_if.sv
// Framebuffer read port and video output bundle of the display scan-out stage.
// The scan-out block drives through the master modport; the framebuffer/pins side uses slave.
interface display_scanout_if #(
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 240
);
  localparam int FB_X_W = $clog2(FB_WIDTH);
  localparam int FB_Y_W = $clog2(FB_HEIGHT);

  logic [FB_X_W-1:0] fb_x;
  logic [FB_Y_W-1:0] fb_y;
  logic [15:0]       fb_pixel;
  logic [15:0]       rgb;
  logic              hsync;
  logic              vsync;
  logic              de;
  logic              frame_start;

  modport master (
    output fb_x, fb_y, rgb, hsync, vsync, de, frame_start,
    input  fb_pixel
  );

  modport slave (
    input  fb_x, fb_y, rgb, hsync, vsync, de, frame_start,
    output fb_pixel
  );
endinterface

// File: rtl/display_scanout.sv
// Raster timing generator and pixel-doubling scan-out for a framebuffer feeding a VGA-style output.
// Control signals are delayed to line up with the framebuffer read data, then registered together.
module display_scanout #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int FB_WIDTH        = 320,
  parameter int FB_HEIGHT       = 240,
  parameter int SCALE_LOG2      = 1,
  parameter int RD_LATENCY      = 1,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst,
  display_scanout_if.master   bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_CNT_W = $clog2(H_TOTAL);
  localparam int V_CNT_W = $clog2(V_TOTAL);
  localparam int FB_X_W  = $clog2(FB_WIDTH);
  localparam int FB_Y_W  = $clog2(FB_HEIGHT);

  localparam logic [H_CNT_W-1:0] H_ZERO_C = H_CNT_W'(0);
  localparam logic [H_CNT_W-1:0] H_ONE_C  = H_CNT_W'(1);
  localparam logic [H_CNT_W-1:0] H_ACT_C  = H_CNT_W'(H_ACTIVE);
  localparam logic [H_CNT_W-1:0] H_SS_C   = H_CNT_W'(H_ACTIVE + H_FP);
  localparam logic [H_CNT_W-1:0] H_SE_C   = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [H_CNT_W-1:0] H_LAST_C = H_CNT_W'(H_TOTAL - 1);
  localparam logic [V_CNT_W-1:0] V_ZERO_C = V_CNT_W'(0);
  localparam logic [V_CNT_W-1:0] V_ONE_C  = V_CNT_W'(1);
  localparam logic [V_CNT_W-1:0] V_ACT_C  = V_CNT_W'(V_ACTIVE);
  localparam logic [V_CNT_W-1:0] V_SS_C   = V_CNT_W'(V_ACTIVE + V_FP);
  localparam logic [V_CNT_W-1:0] V_SE_C   = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [V_CNT_W-1:0] V_LAST_C = V_CNT_W'(V_TOTAL - 1);

  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } ctl_t;

  localparam ctl_t CTL_IDLE_C = ctl_t'(4'b0000);

  logic [H_CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [V_CNT_W-1:0] v_cnt_q, v_cnt_d;
  ctl_t               raw_s;
  ctl_t               ctl_pipe_q [RD_LATENCY];
  ctl_t               dly_s;
  logic [FB_X_W-1:0]  fb_x_s;
  logic [FB_Y_W-1:0]  fb_y_s;
  logic [15:0]        rgb_q, rgb_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               de_q, de_d;
  logic               fs_q, fs_d;

  // Raster counter next state: h wraps each line, v advances on the h wrap.
  always_comb begin
    h_cnt_d = h_cnt_q + H_ONE_C;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST_C) begin
      h_cnt_d = H_ZERO_C;
      if (v_cnt_q == V_LAST_C) begin
        v_cnt_d = V_ZERO_C;
      end else begin
        v_cnt_d = v_cnt_q + V_ONE_C;
      end
    end else begin
      v_cnt_d = v_cnt_q;
    end
  end

  // Raster counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= H_ZERO_C;
      v_cnt_q <= V_ZERO_C;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Raw control flags and framebuffer address decoded from the counters.
  always_comb begin
    raw_s    = CTL_IDLE_C;
    raw_s.de = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    raw_s.hs = (h_cnt_q >= H_SS_C) && (h_cnt_q < H_SE_C);
    raw_s.vs = (v_cnt_q >= V_SS_C) && (v_cnt_q < V_SE_C);
    raw_s.fs = (h_cnt_q == H_ZERO_C) && (v_cnt_q == V_ZERO_C);
    // Address is parked at 0 in blanking and while reset is held.
    if (!rst && raw_s.de) begin
      fb_x_s = FB_X_W'(h_cnt_q >> SCALE_LOG2);
      fb_y_s = FB_Y_W'(v_cnt_q >> SCALE_LOG2);
    end else begin
      fb_x_s = {FB_X_W{1'b0}};
      fb_y_s = {FB_Y_W{1'b0}};
    end
  end

  // Control delay line matching the framebuffer read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        ctl_pipe_q[i] <= CTL_IDLE_C;
      end
    end else begin
      ctl_pipe_q[0] <= raw_s;
      for (int i = 1; i < RD_LATENCY; i++) begin
        ctl_pipe_q[i] <= ctl_pipe_q[i-1];
      end
    end
  end

  assign dly_s = ctl_pipe_q[RD_LATENCY-1];

  // Output stage next values: blank rgb outside the visible region, apply sync polarity.
  always_comb begin
    rgb_d   = 16'h0000;
    hsync_d = SYNC_IDLE;
    vsync_d = SYNC_IDLE;
    de_d    = dly_s.de;
    fs_d    = dly_s.fs;
    if (dly_s.de) begin
      rgb_d = bus.fb_pixel;
    end else begin
      rgb_d = 16'h0000;
    end
    if (dly_s.hs) begin
      hsync_d = ~SYNC_IDLE;
    end else begin
      hsync_d = SYNC_IDLE;
    end
    if (dly_s.vs) begin
      vsync_d = ~SYNC_IDLE;
    end else begin
      vsync_d = SYNC_IDLE;
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q   <= 16'h0000;
      hsync_q <= SYNC_IDLE;
      vsync_q <= SYNC_IDLE;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
    end
  end

  assign bus.fb_x        = fb_x_s;
  assign bus.fb_y        = fb_y_s;
  assign bus.rgb         = rgb_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.de          = de_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_display_scanout.sv
// Bench for display_scanout: a full-size 640x480 instance and a miniature instance
// (read latency 2, active-high sync) checked every cycle against a raster-position model.
module tb_display_scanout;

  typedef struct packed {
    int   ha; int hf; int hsw; int hb;
    int   va; int vf; int vsw; int vb;
    int   sc; int lat;
    logic alow;
  } cfg_t;

  typedef struct packed {
    int   fb_x; int fb_y; int rgb;
    logic hs; logic vs; logic de; logic fs;
  } exp_t;

  localparam cfg_t CFG_A = '{ha:640, hf:16, hsw:96, hb:48, va:480, vf:10, vsw:2, vb:33,
                             sc:1, lat:1, alow:1'b1};
  localparam cfg_t CFG_B = '{ha:16, hf:2, hsw:3, hb:4, va:12, vf:1, vsw:2, vb:3,
                             sc:1, lat:2, alow:1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1;
  logic force_a = 1'b0, force_b = 1'b0;
  int   cyc_a = 0, cyc_b = 0;
  logic started_a = 1'b0, started_b = 1'b0;
  int   compared = 0, mismatched = 0;
  logic [15:0] pb1_q;

  display_scanout_if #(.FB_WIDTH(320), .FB_HEIGHT(240)) bus_a ();
  display_scanout_if #(.FB_WIDTH(8),   .FB_HEIGHT(6))   bus_b ();

  display_scanout u_a (.clk(clk), .rst(rst_a), .bus(bus_a));

  display_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .FB_WIDTH(8), .FB_HEIGHT(6), .SCALE_LOG2(1), .RD_LATENCY(2), .SYNC_ACTIVE_LOW(0)
  ) u_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  // Framebuffer models: pixel word {row, column}, or all ones while forced.
  always @(posedge clk) begin
    bus_a.fb_pixel <= force_a ? 16'hFFFF : {8'(bus_a.fb_y), 8'(bus_a.fb_x)};
    pb1_q          <= force_b ? 16'hFFFF : {8'(bus_b.fb_y), 8'(bus_b.fb_x)};
    bus_b.fb_pixel <= pb1_q;
  end

  // Clocks elapsed since the last reset edge (counter position before wrapping).
  always @(posedge clk) begin
    if (rst_a) begin cyc_a <= 0; started_a <= 1'b1; end
    else       cyc_a <= cyc_a + 1;
    if (rst_b) begin cyc_b <= 0; started_b <= 1'b1; end
    else       cyc_b <= cyc_b + 1;
  end

  function automatic exp_t model(cfg_t c, int n, logic rst_now, logic frc);
    exp_t e;
    int htot, vtot, ftot, p, h, v, q, hq, vq;
    logic hact, vact;
    htot = c.ha + c.hf + c.hsw + c.hb;
    vtot = c.va + c.vf + c.vsw + c.vb;
    ftot = htot * vtot;
    p = n % ftot;
    h = p % htot;
    v = p / htot;
    e.fb_x = (!rst_now && h < c.ha && v < c.va) ? (h >> c.sc) : 0;
    e.fb_y = (!rst_now && h < c.ha && v < c.va) ? (v >> c.sc) : 0;
    if (n < c.lat + 1) begin
      e.rgb = 0; e.de = 1'b0; e.fs = 1'b0; e.hs = c.alow; e.vs = c.alow;
    end else begin
      q  = (n - c.lat - 1) % ftot;
      hq = q % htot;
      vq = q / htot;
      e.de  = (hq < c.ha) && (vq < c.va);
      e.rgb = !e.de ? 0 : (frc ? 32'h0000FFFF
                               : ((((vq >> c.sc) & 255) << 8) | ((hq >> c.sc) & 255)));
      hact = (hq >= c.ha + c.hf) && (hq < c.ha + c.hf + c.hsw);
      vact = (vq >= c.va + c.vf) && (vq < c.va + c.vf + c.vsw);
      e.hs = c.alow ? !hact : hact;
      e.vs = c.alow ? !vact : vact;
      e.fs = (q == 0);
    end
    return e;
  endfunction

  task automatic check(string nm, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)", nm, $time, act, act, exp, exp);
    end
  endtask

  task automatic cmp(string nm, exp_t e, int fx, int fy, int rgb,
                     logic hs, logic vs, logic de, logic fs);
    compared++;
    if (fx != e.fb_x || fy != e.fb_y || rgb != e.rgb ||
        hs != e.hs || vs != e.vs || de != e.de || fs != e.fs) begin
      mismatched++;
      $display("FAIL %s at %0t: got x=%0d y=%0d rgb=%h hs=%b vs=%b de=%b fs=%b, expected x=%0d y=%0d rgb=%h hs=%b vs=%b de=%b fs=%b",
               nm, $time, fx, fy, rgb, hs, vs, de, fs,
               e.fb_x, e.fb_y, e.rgb, e.hs, e.vs, e.de, e.fs);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (started_a)
      cmp("model_a", model(CFG_A, cyc_a, rst_a, force_a), bus_a.fb_x, bus_a.fb_y, bus_a.rgb,
          bus_a.hsync, bus_a.vsync, bus_a.de, bus_a.frame_start);
    if (started_b)
      cmp("model_b", model(CFG_B, cyc_b, rst_b, force_b), bus_b.fb_x, bus_b.fb_y, bus_b.rgb,
          bus_b.hsync, bus_b.vsync, bus_b.de, bus_b.frame_start);
  end

  task automatic run_a();
    int fbx_tab [6] = '{0, 0, 1, 1, 2, 2};
    int rgb_tab [6] = '{32'h0000, 32'h0000, 32'h0001, 32'h0001, 32'h0002, 32'h0002};
    int de_cnt = 0, hs_cnt = 0, first_hs = -1, fs_other = 0;
    rst_a = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b0;
    for (int k = 0; k <= 2700; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k == 1500) force_a = 1'b1;
      if (k == 2320) force_a = 1'b0;
      if (k == 2700) rst_a = 1'b1;
      @(negedge clk);
      if (k <= 5) check("a_fb_x_seq", int'(bus_a.fb_x), fbx_tab[k]);
      if (k >= 2 && k <= 7) check("a_rgb_seq", int'(bus_a.rgb), rgb_tab[k-2]);
      if (k == 2) begin
        check("a_first_de", int'(bus_a.de), 1);
        check("a_first_fs", int'(bus_a.frame_start), 1);
      end
      if (k >= 3) fs_other += int'(bus_a.frame_start);
      if (k >= 2 && k < 802) begin
        de_cnt += int'(bus_a.de);
        if (!bus_a.hsync) begin
          hs_cnt++;
          if (first_hs < 0) first_hs = k;
        end
      end
      if (k == 1600 || k == 2400) check("a_fb_y_line2_3", int'(bus_a.fb_y), 1);
      if (k == 1602) check("a_rgb_forced_vis", int'(bus_a.rgb), 32'hFFFF);
      if (k == 2242) check("a_rgb_forced_blank", int'(bus_a.rgb), 0);
    end
    check("a_de_per_line", de_cnt, 640);
    check("a_hsync_width", hs_cnt, 96);
    check("a_hsync_start", first_hs, 658);
    check("a_fs_extra", fs_other, 0);
    @(posedge clk);
    #1 rst_a = 1'b0;
    @(negedge clk);
    check("a_rst_de", int'(bus_a.de), 0);
    check("a_rst_rgb", int'(bus_a.rgb), 0);
    check("a_rst_hsync", int'(bus_a.hsync), 1);
    check("a_rst_vsync", int'(bus_a.vsync), 1);
    check("a_rst_fb_x", int'(bus_a.fb_x), 0);
    fs_other = 0;
    for (int k = 1; k <= 900; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (k == 2) check("a_fs_after_rst", int'(bus_a.frame_start), 1);
      else        fs_other += int'(bus_a.frame_start);
    end
    check("a_fs_after_rst_extra", fs_other, 0);
  endtask

  task automatic run_b();
    int fs_cnt = 0, fs_first = -1, fs_second = -1, vs_cnt = 0, de_cnt = 0;
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b0;
    for (int k = 0; k <= 1035; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k == 350) force_b = 1'b1;
      if (k == 800) force_b = 1'b0;
      if (k == 1035) rst_b = 1'b1;
      @(negedge clk);
      if (bus_b.frame_start) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = k;
        else if (fs_second < 0) fs_second = k;
      end
      if (k >= 3 && k < 453) begin
        vs_cnt += int'(bus_b.vsync);
        de_cnt += int'(bus_b.de);
      end
      if (k == 453) check("b_rgb_forced", int'(bus_b.rgb), 32'hFFFF);
      if (k == 829) check("b_rgb_vblank_forced", int'(bus_b.rgb), 0);
    end
    check("b_fs_first", fs_first, 3);
    check("b_fs_period", fs_second - fs_first, 450);
    check("b_fs_count", fs_cnt, 3);
    check("b_vsync_cycles", vs_cnt, 50);
    check("b_de_cycles", de_cnt, 192);
    @(posedge clk);
    #1 rst_b = 1'b0;
    @(negedge clk);
    check("b_rst_hsync", int'(bus_b.hsync), 0);
    check("b_rst_vsync", int'(bus_b.vsync), 0);
    check("b_rst_de", int'(bus_b.de), 0);
    fs_cnt = 0; fs_first = -1;
    for (int k = 1; k <= 950; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus_b.frame_start) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = k;
      end
    end
    check("b_fs_after_rst", fs_first, 3);
    check("b_fs_after_rst_count", fs_cnt, 3);
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
